timer_irq: RTL and testbench

Memory-mapped 16-bit interval timer that responds to CPU bus accesses and drives the CPU `IRQ` input, currently tied low in the core. It sits beside RAM, ROM and GPIO in the address decode. It takes a chip select and write enable from the core, returns read data one clock later to match the core's registered chip-select read mux, and raises a level interrupt when the count expires.

---
 rtl/timer_irq.sv | 108 ++++++++++
 tb/tb_timer_irq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq.sv
// Memory-mapped 16-bit interval timer with prescaler, sticky expiry flag and level IRQ.
// Read data is registered one clock after the chip-select edge to match the core's read mux.
module timer_irq #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0]  reload_lo;
  logic [7:0]  reload_hi;
  logic        en;
  logic        ie;
  logic        oneshot;
  logic        exp_flag;
  logic [15:0] count;
  logic [7:0]  presc;
  logic [7:0]  snap;

  logic        wr;
  logic        rd;
  logic        ctrl_wr;
  logic        status_clr;
  logic        start;
  logic        tick;
  logic        expire;
  logic [15:0] reload;
  logic [7:0]  rd_val;

  assign wr         = cs & we;
  assign rd         = cs & ~we;
  assign ctrl_wr    = wr && (addr == 3'd2);
  assign status_clr = wr && (addr == 3'd3) && data_in[0];
  assign reload     = {reload_hi, reload_lo};
  assign tick       = en && (presc == PRE_LAST);
  assign expire     = tick && (count == 16'd0);
  // EN rising by software write; a tick cannot coincide because the prescaler is frozen while EN=0
  assign start      = ctrl_wr && !en && data_in[0];

  // Both operands are flops, so the interrupt line cannot glitch
  assign irq = exp_flag & ie;

  always_comb begin
    rd_val = 8'h00;
    case (addr)
      3'd0:    rd_val = reload_lo;
      3'd1:    rd_val = reload_hi;
      3'd2:    rd_val = {5'b0, oneshot, ie, en};
      3'd3:    rd_val = {7'b0, exp_flag};
      3'd4:    rd_val = count[7:0];
      3'd5:    rd_val = snap;
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_lo <= 8'h00;
      reload_hi <= 8'h00;
      en        <= 1'b0;
      ie        <= 1'b0;
      oneshot   <= 1'b0;
      exp_flag  <= 1'b0;
      count     <= 16'h0000;
      presc     <= 8'h00;
      snap      <= 8'h00;
      data_out  <= 8'h00;
    end else begin
      if (wr && (addr == 3'd0)) reload_lo <= data_in;
      if (wr && (addr == 3'd1)) reload_hi <= data_in;

      // A CTRL write overrides the one-shot auto-disable on the same edge
      if (ctrl_wr) begin
        en      <= data_in[0];
        ie      <= data_in[1];
        oneshot <= data_in[2];
      end else if (expire && oneshot) begin
        en <= 1'b0;
      end

      if (expire)          exp_flag <= 1'b1;
      else if (status_clr) exp_flag <= 1'b0;

      if (start) begin
        count <= reload;
        presc <= 8'h00;
      end else if (en) begin
        presc <= tick ? 8'h00 : presc + 8'd1;
        if (tick) count <= (count == 16'd0) ? reload : count - 16'd1;
      end

      // COUNT_LO read freezes the high byte so a following COUNT_HI read is coherent
      if (rd) begin
        data_out <= rd_val;
        if (addr == 3'd4) snap <= count[15:8];
      end
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: directed scenarios plus randomized reload values,
// checked against closed-form expectations of count and expiry time.
module tb_timer_irq;

  localparam int PRES = 4;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  timer_irq #(.PRESCALE(PRES)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Count k clocks after the start edge: one tick every PRES clocks, cycling R, R-1, .., 0, R, ..
  function automatic int model_count(input int r, input int k);
    return r - ((k / PRES) % (r + 1));
  endfunction

  function automatic int model_period(input int r);
    return (r + 1) * PRES;
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
    d = data_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input int limit, output bit ok, output int edge_no);
    ok = 1'b0;
    edge_no = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin
        ok = 1'b1;
        edge_no = cyc;
        break;
      end
    end
  endtask

  task automatic start_timer(input logic [15:0] r, input logic [7:0] ctrl, output int s);
    bus_write(3'd2, 8'h00);
    bus_write(3'd3, 8'h01);
    bus_write(3'd0, r[7:0]);
    bus_write(3'd1, r[15:8]);
    bus_write(3'd2, ctrl);
    s = cyc;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; data_in = 8'h00;
    #12;
    n_cmp++;
    if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge clk); reset = 1'b0;
    bus_read(3'd2, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl: got %h want 00", d); end
  endtask

  task automatic test_bus;
    logic [7:0] d;
    logic [7:0] v;
    bus_read(3'd6, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL addr6_read: got %h want 00", d); end
    bus_write(3'd0, 8'h5A);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = 3'd0;
    n_cmp++;
    if (data_out !== 8'h00) begin n_bad++; $display("FAIL read_early: got %h want 00", data_out); end
    @(posedge clk); #1;
    cs = 1'b0;
    n_cmp++;
    if (data_out !== 8'h5A) begin n_bad++; $display("FAIL read_lat: got %h want 5a", data_out); end
    idle(3);
    n_cmp++;
    if (data_out !== 8'h5A) begin n_bad++; $display("FAIL read_hold: got %h want 5a", data_out); end
    bus_write(3'd6, 8'hFF);
    bus_read(3'd6, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL addr6_after_write: got %h want 00", d); end
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      bus_write(3'(i % 2), v);
      bus_read(3'(i % 2), d);
      n_cmp++;
      if (d !== v) begin n_bad++; $display("FAIL reload_rw[%0d]: got %h want %h", i, d, v); end
    end
    bus_write(3'd2, 8'hFE);
    bus_read(3'd2, d);
    n_cmp++;
    if (d !== 8'h06) begin n_bad++; $display("FAIL ctrl_mask: got %h want 06", d); end
    bus_write(3'd2, 8'h00);
    bus_write(3'd0, 8'h34);
    bus_write(3'd1, 8'h12);
    bus_write(3'd2, 8'h01);
    bus_write(3'd2, 8'h00);
    bus_read(3'd4, d);
    n_cmp++;
    if (d !== 8'h34) begin n_bad++; $display("FAIL count_lo_frozen: got %h want 34", d); end
    bus_read(3'd5, d);
    n_cmp++;
    if (d !== 8'h12) begin n_bad++; $display("FAIL count_hi_frozen: got %h want 12", d); end
    bus_write(3'd5, 8'h00);
    bus_write(3'd4, 8'h00);
    bus_read(3'd5, d);
    n_cmp++;
    if (d !== 8'h12) begin n_bad++; $display("FAIL count_hi_write_ignored: got %h want 12", d); end
    bus_read(3'd4, d);
    n_cmp++;
    if (d !== 8'h34) begin n_bad++; $display("FAIL count_lo_write_ignored: got %h want 34", d); end
  endtask

  task automatic test_periodic;
    logic [7:0] d;
    int s;
    int e;
    bit ok;
    start_timer(16'h0003, 8'h03, s);
    wait_irq(100, ok, e);
    n_cmp++;
    if (!ok || e != s + 16) begin n_bad++; $display("FAIL periodic_first: got edge %0d want %0d", e - s, 16); end
    bus_write(3'd3, 8'h01);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL periodic_clear: got irq %b want 0", irq); end
    wait_irq(100, ok, e);
    n_cmp++;
    if (!ok || e != s + 32) begin n_bad++; $display("FAIL periodic_second: got edge %0d want %0d", e - s, 32); end
    bus_write(3'd3, 8'h01);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL periodic_clear2: got irq %b want 0", irq); end
    for (int i = 0; i < 40 && cyc < s + 47; i++) begin
      @(posedge clk); #1;
    end
    bus_write(3'd3, 8'h01);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL race_irq: got %b want 1", irq); end
    bus_read(3'd3, d);
    n_cmp++;
    if (d !== 8'h01) begin n_bad++; $display("FAIL race_exp: got %h want 01", d); end
    bus_write(3'd2, 8'h01);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL ie_clear_irq: got %b want 0", irq); end
    bus_write(3'd2, 8'h00);
  endtask

  task automatic test_oneshot;
    logic [7:0] d;
    int s;
    int e;
    bit ok;
    start_timer(16'h0002, 8'h07, s);
    wait_irq(60, ok, e);
    n_cmp++;
    if (!ok || e != s + 12) begin n_bad++; $display("FAIL oneshot_expiry: got edge %0d want %0d", e - s, 12); end
    bus_read(3'd2, d);
    n_cmp++;
    if (d !== 8'h06) begin n_bad++; $display("FAIL oneshot_ctrl: got %h want 06", d); end
    bus_write(3'd3, 8'h01);
    idle(100);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL oneshot_no_repeat: got irq %b want 0", irq); end
    bus_read(3'd3, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL oneshot_status: got %h want 00", d); end
    bus_read(3'd4, d);
    n_cmp++;
    if (d !== 8'h02) begin n_bad++; $display("FAIL oneshot_reloaded: got %h want 02", d); end
    bus_write(3'd2, 8'h00);
  endtask

  task automatic test_coherent;
    logic [7:0] lo;
    logic [7:0] hi;
    int s;
    int want;
    start_timer(16'h0100, 8'h01, s);
    for (int i = 0; i < 4; i++) begin
      bus_read(3'd4, lo);
      want = model_count(256, cyc - 1 - s);
      bus_read(3'd5, hi);
      n_cmp++;
      if ({hi, lo} !== 16'(want) || {hi, lo} === 16'h01FF || {hi, lo} === 16'h0000) begin
        n_bad++; $display("FAIL coherent[%0d]: got %h want %h", i, {hi, lo}, 16'(want));
      end
    end
    bus_write(3'd2, 8'h00);
  endtask

  task automatic test_random;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [15:0] r;
    int s;
    int e;
    int want;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      r = 16'($urandom_range(0, 6));
      start_timer(r, 8'h03, s);
      wait_irq(200, ok, e);
      n_cmp++;
      if (!ok || e - s != model_period(int'(r))) begin
        n_bad++; $display("FAIL rand_period[%0d]: reload %0d got %0d want %0d", i, r, e - s, model_period(int'(r)));
      end
    end
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      start_timer(r, 8'h01, s);
      idle($urandom_range(0, 30));
      bus_read(3'd4, lo);
      want = model_count(int'(r), cyc - 1 - s);
      bus_read(3'd5, hi);
      n_cmp++;
      if ({hi, lo} !== 16'(want)) begin
        n_bad++; $display("FAIL rand_count[%0d]: reload %h got %h want %h", i, r, {hi, lo}, 16'(want));
      end
    end
    bus_write(3'd2, 8'h00);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int s;
    int e;
    bit ok;
    start_timer(16'h0000, 8'h03, s);
    wait_irq(40, ok, e);
    n_cmp++;
    if (!ok || e != s + 4) begin n_bad++; $display("FAIL reload0_expiry: got edge %0d want 4", e - s); end
    bus_read(3'd2, d);
    n_cmp++;
    if (d !== 8'h03) begin n_bad++; $display("FAIL pre_reset_ctrl: got %h want 03", d); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (irq !== 1'b0 || data_out !== 8'h00) begin
      n_bad++; $display("FAIL async_reset: got irq %b data %h want 0 00", irq, data_out);
    end
    @(negedge clk); reset = 1'b0;
    idle(50);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL post_reset_irq: got %b want 0", irq); end
    bus_read(3'd2, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL post_reset_ctrl: got %h want 00", d); end
    bus_read(3'd3, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL post_reset_status: got %h want 00", d); end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_periodic();
    test_oneshot();
    test_coherent();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
